// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop-response driver: state encoding,
// CRRESP bit positions and the default CD burst length.
package ace_snoop_pkg;

  localparam logic [1:0] RS_IDLE   = 2'd0;
  localparam logic [1:0] RS_ACTIVE = 2'd1;
  localparam logic [1:0] RS_RETIRE = 2'd2;

  localparam int unsigned CRRESP_W             = 5;
  localparam int unsigned CRRESP_DATA_TRANSFER = 0;
  localparam int unsigned CRRESP_ERROR         = 1;
  localparam int unsigned CRRESP_PASS_DIRTY    = 2;
  localparam int unsigned CRRESP_IS_SHARED     = 3;
  localparam int unsigned CRRESP_WAS_UNIQUE    = 4;

  // 64 B line carried as 16 B beats
  localparam int unsigned CD_BEATS_DEFAULT = 4;

  // Low byte of a CD beat: beat-0 byte plus beat index, wrapping mod 256
  function automatic logic [7:0] beat_byte(input logic [7:0] base, input logic [7:0] beat);
    return base + beat;
  endfunction

endpackage

// File: rtl/snoop_cmd_fifo.sv
// Small synchronous FIFO holding queued snoop-response commands.
// Pushes while full and pops while empty are ignored.
module snoop_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Status flags and next pointers; extra pointer bit separates full from empty
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PW'(1) : rptr_q;
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ace_snoop_resp_driver.sv
// Converts queued snoop-response commands into ACE CR/CD channel transfers
// and keeps retire/stall/timeout statistics for the status registers.
module ace_snoop_resp_driver
  import ace_snoop_pkg::*;
#(
  parameter int unsigned C_ACE_DATA_WIDTH   = 128,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned CD_BEATS           = CD_BEATS_DEFAULT,
  parameter int unsigned CMD_DEPTH          = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [4:0]                    i_cmd_crresp,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_cmd_data,
  input  logic                          i_clear,
  output logic                          o_crvalid,
  input  logic                          i_crready,
  output logic [4:0]                    o_crresp,
  output logic                          o_cdvalid,
  input  logic                          i_cdready,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_cddata,
  output logic                          o_cdlast,
  output logic                          o_busy,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_resp_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_stall_max,
  output logic                          o_timeout
);

  localparam int unsigned DW    = C_ACE_DATA_WIDTH;
  localparam int unsigned SW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned FifoW = CRRESP_W + DW;
  localparam int unsigned BeatW = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;

  localparam logic [BeatW-1:0] LastBeat   = BeatW'(CD_BEATS - 1);
  localparam logic [SW-1:0]    TimeoutLim = SW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]    SatMax     = '1;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FifoW-1:0] fifo_rdata;

  logic [1:0]       state_q, state_d;
  logic             crvalid_q, crvalid_d, cdvalid_q, cdvalid_d;
  logic             cr_done_q, cr_done_d, cd_done_q, cd_done_d;
  logic [4:0]       crresp_q, crresp_d;
  logic [DW-1:0]    data_q, data_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [SW-1:0]    stall_q, stall_d, resp_cnt_q, resp_cnt_d, stall_max_q, stall_max_d;
  logic             timeout_q, timeout_d;
  logic             cr_hs, cd_hs;

  snoop_cmd_fifo #(
    .Width (FifoW),
    .Depth (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (ace_aclk),
    .rst_i   (ace_areset),
    .push_i  (i_cmd_valid),
    .wdata_i ({i_cmd_crresp, i_cmd_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Response sequencing, burst beat tracking and statistics
  always_comb begin
    state_d     = state_q;
    crvalid_d   = crvalid_q;
    cdvalid_d   = cdvalid_q;
    cr_done_d   = cr_done_q;
    cd_done_d   = cd_done_q;
    crresp_d    = crresp_q;
    data_d      = data_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    resp_cnt_d  = resp_cnt_q;
    stall_max_d = stall_max_q;
    timeout_d   = timeout_q;
    fifo_pop    = 1'b0;
    cr_hs       = crvalid_q & i_crready;
    cd_hs       = cdvalid_q & i_cdready;

    unique case (state_q)
      RS_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          crresp_d  = fifo_rdata[FifoW-1 -: CRRESP_W];
          data_d    = fifo_rdata[DW-1:0];
          beat_d    = '0;
          stall_d   = '0;
          crvalid_d = 1'b1;
          cr_done_d = 1'b0;
          cdvalid_d = crresp_d[CRRESP_DATA_TRANSFER];
          cd_done_d = ~crresp_d[CRRESP_DATA_TRANSFER];
          state_d   = RS_ACTIVE;
        end
      end
      RS_ACTIVE: begin
        stall_d = (stall_q == SatMax) ? stall_q : stall_q + SW'(1);
        // The transfer is never aborted; the flag only reports the stall
        if (stall_d >= TimeoutLim) timeout_d = 1'b1;
        if (cr_hs) begin
          crvalid_d = 1'b0;
          cr_done_d = 1'b1;
        end
        if (cd_hs) begin
          if (beat_q == LastBeat) begin
            cdvalid_d = 1'b0;
            cd_done_d = 1'b1;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
        if (cr_done_d && cd_done_d) state_d = RS_RETIRE;
      end
      RS_RETIRE: begin
        if (resp_cnt_q != SatMax) resp_cnt_d = resp_cnt_q + SW'(1);
        if (stall_q > stall_max_q) stall_max_d = stall_q;
        state_d = RS_IDLE;
      end
      default: state_d = RS_IDLE;
    endcase

    // Clear takes priority over a retire or timeout in the same cycle
    if (i_clear) begin
      resp_cnt_d  = '0;
      stall_max_d = '0;
      timeout_d   = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      state_q     <= RS_IDLE;
      crvalid_q   <= 1'b0;
      cdvalid_q   <= 1'b0;
      cr_done_q   <= 1'b0;
      cd_done_q   <= 1'b0;
      crresp_q    <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      stall_q     <= '0;
      resp_cnt_q  <= '0;
      stall_max_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crvalid_q   <= crvalid_d;
      cdvalid_q   <= cdvalid_d;
      cr_done_q   <= cr_done_d;
      cd_done_q   <= cd_done_d;
      crresp_q    <= crresp_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      resp_cnt_q  <= resp_cnt_d;
      stall_max_q <= stall_max_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs are pure functions of registered state, so they stay stable while stalled
  always_comb begin
    o_cmd_ready  = ~fifo_full;
    o_crvalid    = crvalid_q;
    o_crresp     = crresp_q;
    o_cdvalid    = cdvalid_q;
    o_cddata     = {data_q[DW-1:8], beat_byte(data_q[7:0], 8'(beat_q))};
    o_cdlast     = cdvalid_q && (beat_q == LastBeat);
    o_busy       = ~fifo_empty || (state_q != RS_IDLE);
    o_resp_count = resp_cnt_q;
    o_stall_max  = stall_max_q;
    o_timeout    = timeout_q;
  end

endmodule
